// File: rtl/definitions.sv
// Shared core definitions: ALU opcodes, multiply-sequencer state names and constants.
package definitions;

  typedef enum logic [2:0] {
    kNOP = 3'd0,
    kADD = 3'd1,
    kSUB = 3'd2,
    kAND = 3'd3,
    kOR  = 3'd4,
    kXOR = 3'd5,
    kLSH = 3'd6
  } op_mne;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHH  = 3'd2,
    SHL  = 3'd3,
    DONE = 3'd4
  } mul_state_t;

  localparam int kMulIters = 8;

endpackage

// File: rtl/alu.sv
// Shared 8-bit ALU: add/sub with carry, bitwise ops, and a barrel shift
// (in_b[2:0] positions, rsh selects direction).
module alu
  import definitions::*;
(
  input  logic [2:0] op,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       ci,
  input  logic       rsh,
  output logic [7:0] rslt,
  output logic       co,
  output logic       z
);

  always_comb begin
    rslt = '0;
    co   = 1'b0;
    case (op_mne'(op))
      kADD: {co, rslt} = {1'b0, in_a} + {1'b0, in_b} + {8'd0, ci};
      kSUB: {co, rslt} = {1'b0, in_a} - {1'b0, in_b} - {8'd0, ci};
      kAND: rslt = in_a & in_b;
      kOR:  rslt = in_a | in_b;
      kXOR: rslt = in_a ^ in_b;
      kLSH: rslt = rsh ? (in_a >> in_b[2:0]) : (in_a << in_b[2:0]);
      default: rslt = '0;
    endcase
    z = (rslt == '0);
  end

endmodule

// File: rtl/mul_seq.sv
// 8x8->16 unsigned shift-and-add multiplier that borrows the shared ALU for
// every add and shift; this block only steers operands and re-inserts carry bits.
//
// state | meaning
// IDLE  | waiting for start; last product held on prod_hi/prod_lo
// ADD   | {cbit,hi} <= hi + (lo[0] ? mc : 0)
// SHH   | hi <= {cbit, hi >> 1}, sbit <= hi[0]
// SHL   | lo <= {sbit, lo >> 1}; eighth pass goes to DONE
// DONE  | one-cycle done pulse, product valid
module mul_seq
  import definitions::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] mcand,
  input  logic [W-1:0] mplier,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] prod_hi,
  output logic [W-1:0] prod_lo,
  output logic         alu_own,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_in_a,
  output logic [W-1:0] alu_in_b,
  output logic         alu_ci,
  output logic         alu_rsh,
  input  logic [W-1:0] alu_rslt,
  input  logic         alu_co
);

  localparam logic [2:0] kLastIter = 3'(kMulIters - 1);

  mul_state_t   state;
  logic [W-1:0] hi, lo, mc;
  logic [2:0]   cnt;
  logic         cbit, sbit;
  op_mne        op_sel;

  assign prod_hi = hi;
  assign prod_lo = lo;
  assign alu_op  = op_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      mc      <= '0;
      cnt     <= '0;
      cbit    <= 1'b0;
      sbit    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_own <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hi      <= '0;
            lo      <= mplier;
            mc      <= mcand;
            cnt     <= '0;
            state   <= ADD;
            busy    <= 1'b1;
            alu_own <= 1'b1;
          end
        end
        ADD: begin
          hi    <= alu_rslt;
          cbit  <= alu_co;
          state <= SHH;
        end
        SHH: begin
          hi    <= {cbit, alu_rslt[W-2:0]};
          sbit  <= hi[0];
          state <= SHL;
        end
        SHL: begin
          lo  <= {sbit, alu_rslt[W-2:0]};
          cnt <= cnt + 3'd1;
          if (cnt == kLastIter) begin
            state   <= DONE;
            done    <= 1'b1;
            alu_own <= 1'b0;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          alu_own <= 1'b0;
        end
      endcase
    end
  end

  // Operands depend on state and registers only, so no path from alu_rslt back to the ALU.
  always_comb begin
    op_sel   = kNOP;
    alu_in_a = '0;
    alu_in_b = '0;
    alu_ci   = 1'b0;
    alu_rsh  = 1'b0;
    case (state)
      ADD: begin
        op_sel   = kADD;
        alu_in_a = hi;
        alu_in_b = lo[0] ? mc : '0;
      end
      SHH: begin
        op_sel   = kLSH;
        alu_rsh  = 1'b1;
        alu_in_a = hi;
        alu_in_b = W'(1);
      end
      SHL: begin
        op_sel   = kLSH;
        alu_rsh  = 1'b1;
        alu_in_a = lo;
        alu_in_b = W'(1);
      end
      default: ;
    endcase
  end

endmodule
